// File: rtl/l1_refill_ctrl.sv
// L1 miss/refill controller: on a lookup miss it stalls the core, fetches the line,
// writes the beats into the victim way, then writes tag+valid and releases the core.
module l1_refill_ctrl #(
  parameter int IDX_W   = 7,
  parameter int TAG_W   = 20,
  parameter int WAY_NUM = 4,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4,
  parameter int CNT_W   = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lkp_val,
  input  logic [IDX_W-1:0]       lkp_idx,
  input  logic [TAG_W-1:0]       lkp_tag,
  input  logic                   lkp_hit,
  input  logic [WAY_NUM-1:0]     lkp_way_vect,
  output logic                   lkp_stall,
  output logic                   mem_req_val,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr,
  input  logic                   mem_req_rdy,
  input  logic                   mem_rsp_val,
  input  logic [DATA_W-1:0]      mem_rsp_data,
  input  logic                   mem_rsp_err,
  output logic                   data_we,
  output logic [WAY_NUM-1:0]     data_way_vect,
  output logic [IDX_W-1:0]       data_idx,
  output logic [CNT_W-1:0]       data_word,
  output logic [DATA_W-1:0]      data_wdata,
  output logic                   tag_we,
  output logic [WAY_NUM-1:0]     tag_way_vect,
  output logic [IDX_W-1:0]       tag_idx,
  output logic [TAG_W-1:0]       tag_wdata,
  output logic                   tag_wval,
  output logic                   fill_done,
  output logic                   fill_err,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_UPD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WAY_NUM-1:0] way_q, way_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Memory request is a valid/ready handshake: mem_req_val and mem_req_addr hold
  // steady from the first REQ cycle until the cycle where mem_req_rdy is also high.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_req_val = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    tag_wval    = 1'b0;
    fill_done   = 1'b0;
    fill_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lkp_val && !lkp_hit) begin
          idx_d   = lkp_idx;
          tag_d   = lkp_tag;
          way_d   = lkp_way_vect;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_val = 1'b1;
        if (mem_req_rdy) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rsp_val) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          err_d   = err_q | mem_rsp_err;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_UPD;
        end
      end
      S_UPD: begin
        tag_we    = 1'b1;
        tag_wval  = ~err_q;
        fill_done = 1'b1;
        fill_err  = err_q;
        err_d     = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall covers the miss cycle itself so the core never sees a miss un-stalled.
  assign lkp_stall = (state_q != S_IDLE) | (lkp_val & ~lkp_hit);

  // Payload buses are zero whenever their strobe is low.
  assign mem_req_addr  = mem_req_val ? {tag_q, idx_q} : '0;
  assign data_way_vect = data_we ? way_q : '0;
  assign data_idx      = data_we ? idx_q : '0;
  assign data_word     = data_we ? cnt_q : '0;
  assign data_wdata    = data_we ? mem_rsp_data : '0;
  assign tag_way_vect  = tag_we ? way_q : '0;
  assign tag_idx       = tag_we ? idx_q : '0;
  assign tag_wdata     = tag_we ? tag_q : '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Bench for l1_refill_ctrl: a driver plays core and memory and queues the expected
// request/data/tag traffic; a negedge monitor pops and compares every DUT strobe.
module tb_l1_refill_ctrl;
  localparam int IDX_W   = 7;
  localparam int TAG_W   = 20;
  localparam int WAY_NUM = 4;
  localparam int DATA_W  = 32;
  localparam int BEATS   = 4;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int AW      = TAG_W + IDX_W;
  localparam int DW      = WAY_NUM + IDX_W + CNT_W + DATA_W;
  localparam int TW      = WAY_NUM + IDX_W + TAG_W + 3;

  logic                 clk, rst_n;
  logic                 lkp_val, lkp_hit;
  logic [IDX_W-1:0]     lkp_idx;
  logic [TAG_W-1:0]     lkp_tag;
  logic [WAY_NUM-1:0]   lkp_way_vect;
  logic                 lkp_stall;
  logic                 mem_req_val, mem_req_rdy;
  logic [AW-1:0]        mem_req_addr;
  logic                 mem_rsp_val, mem_rsp_err;
  logic [DATA_W-1:0]    mem_rsp_data;
  logic                 data_we;
  logic [WAY_NUM-1:0]   data_way_vect;
  logic [IDX_W-1:0]     data_idx;
  logic [CNT_W-1:0]     data_word;
  logic [DATA_W-1:0]    data_wdata;
  logic                 tag_we;
  logic [WAY_NUM-1:0]   tag_way_vect;
  logic [IDX_W-1:0]     tag_idx;
  logic [TAG_W-1:0]     tag_wdata;
  logic                 tag_wval, fill_done, fill_err;
  logic [1:0]           dbg_state;

  logic [AW-1:0] req_q[$];
  logic [DW-1:0] data_q[$];
  logic [TW-1:0] tag_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  l1_refill_ctrl #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .WAY_NUM(WAY_NUM), .DATA_W(DATA_W), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lkp_val(lkp_val), .lkp_idx(lkp_idx), .lkp_tag(lkp_tag), .lkp_hit(lkp_hit),
    .lkp_way_vect(lkp_way_vect), .lkp_stall(lkp_stall),
    .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .data_we(data_we), .data_way_vect(data_way_vect), .data_idx(data_idx),
    .data_word(data_word), .data_wdata(data_wdata),
    .tag_we(tag_we), .tag_way_vect(tag_way_vect), .tag_idx(tag_idx),
    .tag_wdata(tag_wdata), .tag_wval(tag_wval),
    .fill_done(fill_done), .fill_err(fill_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic any_output();
    return |{lkp_stall, mem_req_val, mem_req_addr, data_we, data_way_vect, data_idx,
             data_word, data_wdata, tag_we, tag_way_vect, tag_idx, tag_wdata,
             tag_wval, fill_done, fill_err};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req_val) begin
          if (req_q.size() == 0) chk("mem_req_unexpected", 1, 0);
          else begin
            chk("mem_req_addr", mem_req_addr, req_q[0]);
            if (mem_req_rdy) void'(req_q.pop_front());
          end
        end
        if (data_we) begin
          if (data_q.size() == 0) chk("data_we_unexpected", 1, 0);
          else chk("data_write", {data_way_vect, data_idx, data_word, data_wdata},
                   data_q.pop_front());
        end
        if (tag_we || fill_done) begin
          if (tag_q.size() == 0) chk("tag_we_unexpected", 1, 0);
          else chk("tag_write", {tag_way_vect, tag_idx, tag_wdata, tag_wval, fill_err, fill_done},
                   tag_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic noise(input bit noisy);
    if (noisy) begin
      lkp_val      = 1'($urandom_range(0, 1));
      lkp_hit      = 1'($urandom_range(0, 1));
      lkp_idx      = IDX_W'($urandom);
      lkp_tag      = TAG_W'($urandom);
      lkp_way_vect = WAY_NUM'($urandom);
    end else begin
      lkp_val = 1'b0;
    end
  endtask

  // gap_mode: 0 back-to-back beats, 1 one idle cycle before each beat, 2 random gaps
  task automatic do_miss(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [WAY_NUM-1:0] way, input int rdy_dly,
                         input int gap_mode, input logic [BEATS-1:0] emask,
                         input bit noisy, input int rst_after, input int exp_done_cyc);
    logic [DATA_W-1:0] beats [BEATS];
    int start, stall_cnt, req_cnt, done_cyc, gaps;
    bit acc, done, quiet_bad;
    start = cyc;
    for (int b = 0; b < BEATS; b++) begin
      beats[b] = $urandom;
      data_q.push_back({way, idx, CNT_W'(b), beats[b]});
    end
    req_q.push_back({tag, idx});
    tag_q.push_back({way, idx, tag, ~(|emask), |emask, 1'b1});

    lkp_val = 1'b1; lkp_hit = 1'b0; lkp_idx = idx; lkp_tag = tag; lkp_way_vect = way;
    mem_req_rdy = 1'b0; mem_rsp_val = 1'b0;
    @(negedge clk);
    stall_cnt = lkp_stall ? 1 : 0;
    step();

    acc = 1'b0; req_cnt = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      noise(noisy);
      mem_req_rdy  = (i >= rdy_dly);
      mem_rsp_val  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rsp_data = $urandom;
      @(negedge clk);
      if (lkp_stall) stall_cnt++;
      if (mem_req_val) req_cnt++;
      acc = mem_req_val && mem_req_rdy;
      step();
    end
    chk("req_accepted", acc, 1);
    chk("req_hold_cycles", req_cnt, rdy_dly + 1);
    mem_req_rdy = 1'b0;
    if (!acc) begin
      req_q.delete(); data_q.delete(); tag_q.delete();
      return;
    end

    for (int b = 0; b < BEATS; b++) begin
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        noise(noisy);
        mem_rsp_val = 1'b0; mem_rsp_data = $urandom; mem_rsp_err = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (lkp_stall) stall_cnt++;
        step();
      end
      noise(noisy);
      mem_rsp_val = 1'b1; mem_rsp_data = beats[b]; mem_rsp_err = emask[b];
      @(negedge clk);
      if (lkp_stall) stall_cnt++;
      step();
      if (b == rst_after) begin
        rst_n = 1'b0; mem_rsp_val = 1'b0; lkp_val = 1'b0; mem_req_rdy = 1'b0;
        data_q.delete(); tag_q.delete(); req_q.delete();
        #1;
        chk("rst_outputs_zero", any_output(), 0);
        chk("rst_state_idle", dbg_state, 0);
        @(negedge clk);
        chk("rst_outputs_zero_cycle", any_output(), 0);
        step();
        rst_n = 1'b1;
        quiet_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          quiet_bad |= tag_we | fill_done | data_we | mem_req_val;
          step();
        end
        chk("post_rst_quiet", quiet_bad, 0);
        chk("post_rst_state_idle", dbg_state, 0);
        return;
      end
    end
    mem_rsp_val = 1'b0; mem_rsp_err = 1'b0;

    done = 1'b0; done_cyc = -1;
    for (int i = 0; i < 10 && !done; i++) begin
      noise(noisy);
      @(negedge clk);
      if (lkp_stall) stall_cnt++;
      if (fill_done) begin done = 1'b1; done_cyc = cyc - start; end
      step();
    end
    chk("fill_done_seen", done, 1);
    chk("stall_cycles", stall_cnt, done_cyc + 1);
    if (exp_done_cyc >= 0) chk("fill_done_latency", done_cyc, exp_done_cyc);

    // replayed lookup now hits and must not stall
    lkp_val = 1'b1; lkp_hit = 1'b1; lkp_idx = idx; lkp_tag = tag; lkp_way_vect = way;
    @(negedge clk);
    chk("stall_released", lkp_stall, 0);
    step();
    lkp_val = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WAY_NUM-1:0] w;
    logic [BEATS-1:0]   em;
    rst_n = 1'b0;
    lkp_val = 1'b0; lkp_hit = 1'b0; lkp_idx = '0; lkp_tag = '0; lkp_way_vect = '0;
    mem_req_rdy = 1'b0; mem_rsp_val = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    step(); step();
    @(negedge clk);
    chk("reset_outputs_zero", any_output(), 0);
    chk("reset_state_idle", dbg_state, 0);
    step();
    rst_n = 1'b1;
    step();

    // hit lookup: no stall, no request
    lkp_val = 1'b1; lkp_hit = 1'b1; lkp_idx = 7'd9; lkp_tag = 20'h12345; lkp_way_vect = 4'b0001;
    @(negedge clk);
    chk("hit_no_stall", lkp_stall, 0);
    chk("hit_no_req", mem_req_val, 0);
    step();
    lkp_val = 1'b0;
    @(negedge clk);
    chk("hit_stays_idle", {mem_req_val, dbg_state}, 0);
    step();

    // miss with immediate grant and back-to-back beats: fill_done on 7th cycle
    do_miss(7'd5, 20'hABCDE, 4'b0100, 0, 0, '0, 1'b0, -1, BEATS + 2);
    // grant held off three cycles
    do_miss(7'd17, 20'h0F0F0, 4'b1000, 3, 0, '0, 1'b0, -1, -1);
    // alternate-cycle beats, error on beat 2
    em = '0; em[2] = 1'b1;
    do_miss(7'd33, 20'h55AA5, 4'b0010, 0, 1, em, 1'b0, -1, -1);

    // spurious beat while idle
    mem_rsp_val = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("idle_spurious_no_we", data_we, 0);
    step();
    mem_rsp_val = 1'b0;

    // lookups thrown at the controller during the refill
    do_miss(7'd100, 20'hFEDCB, 4'b0001, 1, 2, '0, 1'b1, -1, -1);
    // reset after beat 1
    do_miss(7'd77, 20'h13579, 4'b0100, 0, 0, '0, 1'b0, 1, -1);
    // a fresh miss after the aborted one must still work
    do_miss(7'd78, 20'h2468A, 4'b0010, 0, 0, '0, 1'b0, -1, BEATS + 2);

    for (int t = 0; t < 25; t++) begin
      w = '0; w[$urandom_range(0, WAY_NUM - 1)] = 1'b1;
      em = ($urandom_range(0, 3) == 0) ? BEATS'($urandom) : '0;
      do_miss(IDX_W'($urandom), TAG_W'($urandom), w, $urandom_range(0, 3),
              $urandom_range(0, 2), em, 1'($urandom_range(0, 1)), -1, -1);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        lkp_val = 1'b1; lkp_hit = 1'b1;
        mem_rsp_val = 1'($urandom_range(0, 1)); mem_rsp_data = $urandom;
        @(negedge clk);
        chk("idle_hit_no_stall", lkp_stall, 0);
        step();
      end
      lkp_val = 1'b0; mem_rsp_val = 1'b0;
    end

    step(); step();
    chk("queues_drained", req_q.size() + data_q.size() + tag_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
